// File: rtl/bp_update_sched_if.sv
// Retire-side and predictor-side signal bundle for the branch update scheduler.
`ifndef WAYS
`define WAYS 2
`endif
`ifndef XLEN
`define XLEN 32
`endif

interface bp_update_sched_if #(
  parameter int WAYS  = `WAYS,
  parameter int XLEN  = `XLEN,
  parameter int DEPTH = 8
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WAYS-1:0]           in_valid;
  logic [WAYS-1:0][XLEN-1:0] in_PC;
  logic [WAYS-1:0]           in_direction;
  logic [WAYS-1:0][XLEN-1:0] in_target;
  logic                      in_ready;
  logic                      stall;
  logic [WAYS-1:0][XLEN-1:0] PC_update;
  logic [WAYS-1:0]           direction_update;
  logic [WAYS-1:0][XLEN-1:0] target_update;
  logic [WAYS-1:0]           valid_update;
  logic [CNT_W-1:0]          count;
  logic                      empty;

  // Retirement + predictor side (drives commits and stall).
  modport master (
    output in_valid, in_PC, in_direction, in_target, stall,
    input  in_ready, PC_update, direction_update, target_update, valid_update, count, empty
  );

  // Scheduler side.
  modport slave (
    input  in_valid, in_PC, in_direction, in_target, stall,
    output in_ready, PC_update, direction_update, target_update, valid_update, count, empty
  );
endinterface

// File: rtl/bp_update_sched.sv
// Branch-predictor update scheduler: circular queue of committed branches,
// issues an in-order, index-conflict-free prefix per cycle.
`ifndef WAYS
`define WAYS 2
`endif
`ifndef XLEN
`define XLEN 32
`endif

module bp_update_sched #(
  parameter int WAYS     = `WAYS,
  parameter int XLEN     = `XLEN,
  parameter int DEPTH    = 8,
  parameter int IDX_BITS = 7
) (
  input logic               clock,
  input logic               reset,
  bp_update_sched_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [XLEN-1:0]  pc_mem  [DEPTH];
  logic [XLEN-1:0]  tgt_mem [DEPTH];
  logic [DEPTH-1:0] dir_mem;

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d, n_in, n_out;
  logic             in_ready;

  logic [PTR_W-1:0]    wr_ptr [WAYS];
  logic [PTR_W-1:0]    rd_ptr [WAYS];
  logic [IDX_BITS-1:0] cidx   [WAYS];
  logic [WAYS-1:0]     sel;

  logic [WAYS-1:0][XLEN-1:0] pc_q, pc_d, tgt_q, tgt_d;
  logic [WAYS-1:0]           dir_q, dir_d, vld_q, vld_d;

  // A whole group must fit so upstream never sees a partial accept.
  assign in_ready = (CNT_W'(DEPTH) - count_q) >= CNT_W'(WAYS);

  // Compact valid lanes onto consecutive slots starting at tail.
  always_comb begin
    n_in = '0;
    for (int l = 0; l < WAYS; l++) begin
      wr_ptr[l] = tail_q + n_in[PTR_W-1:0];
      if (bus.in_valid[l]) n_in = n_in + CNT_W'(1);
    end
    if (!in_ready) n_in = '0;
  end

  // Issue candidates are the oldest WAYS entries.
  for (genvar k = 0; k < WAYS; k++) begin : g_cand
    assign rd_ptr[k] = head_q + PTR_W'(k);
    assign cidx[k]   = pc_mem[rd_ptr[k]][IDX_BITS+1:2];
  end

  // Select the longest in-order prefix with no repeated predictor index.
  always_comb begin
    logic go;
    sel   = '0;
    n_out = '0;
    go    = !bus.stall;
    for (int k = 0; k < WAYS; k++) begin
      if (CNT_W'(k) >= count_q) go = 1'b0;
      for (int j = 0; j < k; j++)
        if (cidx[j] == cidx[k]) go = 1'b0;
      sel[k] = go;
      if (go) n_out = n_out + CNT_W'(1);
    end
  end

  // Selected entries land in the low lanes; everything else reads as zero.
  always_comb begin
    pc_d  = '0;
    tgt_d = '0;
    dir_d = '0;
    vld_d = '0;
    for (int k = 0; k < WAYS; k++) begin
      if (sel[k]) begin
        pc_d[k]  = pc_mem[rd_ptr[k]];
        tgt_d[k] = tgt_mem[rd_ptr[k]];
        dir_d[k] = dir_mem[rd_ptr[k]];
        vld_d[k] = 1'b1;
      end
    end
  end

  assign head_d  = head_q + n_out[PTR_W-1:0];
  assign tail_d  = tail_q + n_in[PTR_W-1:0];
  assign count_d = count_q + n_in - n_out;

  // Queue pointers and occupancy; reset drops every queued entry at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clock) begin
    for (int l = 0; l < WAYS; l++) begin
      if (in_ready && bus.in_valid[l]) begin
        pc_mem[wr_ptr[l]]  <= bus.in_PC[l];
        tgt_mem[wr_ptr[l]] <= bus.in_target[l];
        dir_mem[wr_ptr[l]] <= bus.in_direction[l];
      end
    end
  end

  // Registered predictor update port.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q  <= '0;
      tgt_q <= '0;
      dir_q <= '0;
      vld_q <= '0;
    end else begin
      pc_q  <= pc_d;
      tgt_q <= tgt_d;
      dir_q <= dir_d;
      vld_q <= vld_d;
    end
  end

  assign bus.in_ready         = in_ready;
  assign bus.PC_update        = pc_q;
  assign bus.target_update    = tgt_q;
  assign bus.direction_update = dir_q;
  assign bus.valid_update     = vld_q;
  assign bus.count            = count_q;
  assign bus.empty            = (count_q == '0);
endmodule

// File: doc/bp_update_sched.md
# bp_update_sched

Commit-side scheduler for branch-predictor training updates. It accepts up to `WAYS` committed branch outcomes per cycle from retirement into a circular queue. Each cycle it issues an in-order prefix of queued updates to the predictor's `PC_update`/`direction_update`/`target_update`/`valid_update` port. Within one issue group no two updates may map to the same predictor index, so the predictor never sees conflicting same-index writes in one cycle.

## Interface
Parameters:
- `WAYS`, default `` `WAYS ``: lanes in and out per cycle.
- `DEPTH`, default 8: queue entries. Power of two, ≥ 2·`WAYS`.
- `IDX_BITS`, default 7: predictor index width. The index is `PC[IDX_BITS+1:2]`, matching a 128-entry predictor.

Ports:
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `in_valid` in `WAYS`: per-lane committed branch valid.
- `in_PC` in `WAYS`×`XLEN`: branch PC.
- `in_direction` in `WAYS`: 1 = taken.
- `in_target` in `WAYS`×`XLEN`: resolved target.
- `in_ready` out 1: the queue accepts a full group this cycle.
- `stall` in 1: predictor cannot take updates; suppresses issue.
- `PC_update` out `WAYS`×`XLEN`: issued PC, registered.
- `direction_update` out `WAYS`: issued direction, registered.
- `target_update` out `WAYS`×`XLEN`: issued target, registered.
- `valid_update` out `WAYS`: issued lane valid, registered, always a contiguous prefix from lane 0.
- `count` out `$clog2(DEPTH)+1`: occupied entries.
- `empty` out 1: `count == 0`.

## Operation
- Storage: `DEPTH` entries of {PC, direction, target}. Head and tail pointers are `$clog2(DEPTH)` bits and wrap modulo `DEPTH`. `count` ranges 0..`DEPTH`.
- `in_ready` is `(DEPTH - count) >= WAYS`. It is combinational from the registered `count`.
- Enqueue happens only when `in_ready=1`.
  - Valid lanes are compacted in lane order into tail, tail+1, …; invalid lanes leave no hole.
  - `n_in` = popcount(`in_valid`).
  - When `in_ready=0`, `in_valid` is ignored and nothing is written. Upstream must hold its data.
- Issue selection uses current queue contents; entries enqueued this cycle are not eligible.
  - Candidate k (0 ≤ k < `WAYS`) is entry head+k (mod `DEPTH`).
  - Candidate k is selected iff `stall=0`, k < `count`, candidate k−1 was selected (for k>0), and its index differs from the indices of candidates 0..k−1.
  - `n_out` = number selected. Selected entries are dequeued and head advances by `n_out`.
- Output registers load the selected entries in lanes 0..`n_out`−1, with `valid_update` set for those lanes and 0 for the rest.
  - Non-selected lanes drive PC/target/direction as 0.
  - When nothing is selected, all `valid_update` bits are 0 next cycle.
- `count_next` = `count + n_in − n_out`. Enqueue and dequeue in the same cycle are legal at any occupancy.
- Updates reach the predictor in strict commit order; none is dropped or merged.
- Reset (`reset=0`, asynchronous) forces:
  - head = tail = 0, `count=0`, `empty=1`, `in_ready=1`;
  - all `valid_update` bits 0, and `PC_update`, `target_update`, `direction_update` all 0.
  - Queue storage contents need not be cleared.
- Reset asserted mid-operation discards every queued entry immediately, without waiting for a clock edge.

## Timing
- Enqueue at edge N makes the entry visible at N+1. It is selected no earlier than N+1 and appears on `valid_update` from edge N+1 to N+2, i.e. two cycles after presentation.
- Issue throughput is `WAYS` updates per cycle when there are no index conflicts and `stall=0`.
- A same-index pair is split across consecutive cycles.
- `stall` is sampled in the selection cycle. An update already in the output registers is still presented the following cycle.
- Reset release is synchronous to `clock`; the first enqueue is accepted on the first edge with `reset=1`.

## Test plan
- **Reset:** assert `reset=0` asynchronously between edges → `valid_update=0`, `count=0`, `empty=1`, `in_ready=1` immediately.
- **Single update** (`WAYS=2`): at cycle N drive `in_valid=2'b10`, PC=0x100, taken, target=0x200 → `count=1` after edge N. At N+2, `valid_update=2'b01`, `PC_update[0]=0x100`, `target_update[0]=0x200`, `direction_update[0]=1`, and `count=0`.
- **Index conflict:** enqueue lane0 PC=0x100 and lane1 PC=0x300 (both index 0x40) in one cycle → two consecutive cycles each with `valid_update=2'b01`, 0x100 first. PCs 0x100 and 0x104 instead issue together as 2'b11.
- **Full/backpressure:** with `stall=1` (`DEPTH=8`), enqueue 2 per cycle for 4 cycles → `count` goes 2,4,6,8 and `in_ready=0` at 8. A valid group held while not ready is not written. Deassert `stall` → 4 cycles of 2'b11 in commit order, exercising pointer wrap. The held group is accepted once `count` reaches 6.
- **Simultaneous enq/deq:** at `count=6`, `stall=0`, enqueue 2 while 2 issue → `count` stays 6 and order is preserved.
- **Reset mid-drain:** with `count=5` and issue in progress, assert `reset=0` → outputs clear immediately. After release, the first new update issues with no stale entries.
